jpeg_bit_packer: RTL and testbench

Downstream neighbour of jpeg_huffman_encode. Takes its variable-length, right-aligned code words (up to 32 bits per write) and packs them MSB-first into a continuous byte stream. Applies JPEG byte stuffing: every emitted 0xFF is followed by 0x00. On request, pads a trailing partial byte with 1s to the byte boundary. Output bytes feed the scan-data FIFO/serializer over a valid/ready handshake.

---
 rtl/jpeg_pkg.sv | 15 +
 rtl/jpeg_byte_stuffer.sv | 39 +++
 rtl/jpeg_bit_packer.sv | 99 +++++++++
 tb/tb_jpeg_bit_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and the bit-packer state type used by the JPEG entropy-coding back end.
package jpeg_pkg;

  localparam logic [7:0]  JPEG_MARKER_BYTE  = 8'hFF;
  localparam logic [7:0]  JPEG_STUFF_BYTE   = 8'h00;
  localparam int unsigned JPEG_MAX_CODE_LEN = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PAD,
    DONE
  } packer_state_t;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// One-byte output register with valid/ready handshake; inserts 0x00 after every 0xFF it emits.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clock,
  input  logic       nreset,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       can_load,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       stuff_pending
);

  always_comb begin
    can_load = !stuff_pending && (!out_valid || out_ready);
  end

  // stuff_pending is only set while the 0xFF is held, so its handshake
  // is what releases the 0x00, ahead of any new load.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      stuff_pending <= 1'b0;
    end else if (stuff_pending && out_valid && out_ready) begin
      out_data      <= JPEG_STUFF_BYTE;
      stuff_pending <= 1'b0;
    end else if (load) begin
      out_data      <= load_byte;
      out_valid     <= 1'b1;
      stuff_pending <= (load_byte == JPEG_MARKER_BYTE);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length code words MSB-first into a stuffed JPEG byte stream.
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int unsigned ACC_WIDTH    = 64,
  parameter int unsigned MAX_CODE_LEN = JPEG_MAX_CODE_LEN
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  input  logic [5:0]  in_length,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        flush_done
);

  localparam int unsigned CW = $clog2(ACC_WIDTH + 1);

  packer_state_t          state, state_next;
  logic [ACC_WIDTH-1:0]   acc, merged, acc_next;
  logic [CW-1:0]          bit_count, merged_count, count_next, len_ext, ins_shift;
  logic [32:0]            len_mask;
  logic [31:0]            code_bits;
  logic [7:0]             pad_byte, byte_in;
  logic                   accept, extract, pad_load, byte_load;
  logic                   can_load, stuff_pending;

  jpeg_byte_stuffer u_stuffer (
    .clock         (clock),
    .nreset        (nreset),
    .load          (byte_load),
    .load_byte     (byte_in),
    .can_load      (can_load),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .stuff_pending (stuff_pending)
  );

  // Bits are held left-aligned; the incoming word is merged first so a byte
  // completed by this write can be extracted in the same cycle.
  always_comb begin
    accept       = in_valid && in_ready;
    len_mask     = (33'd1 << in_length) - 33'd1;
    code_bits    = accept ? (in_data & len_mask[31:0]) : '0;
    len_ext      = accept ? CW'(in_length) : '0;
    ins_shift    = CW'(ACC_WIDTH) - bit_count - len_ext;
    merged       = acc | (ACC_WIDTH'(code_bits) << ins_shift);
    merged_count = bit_count + len_ext;

    extract   = can_load && (merged_count >= CW'(8));
    pad_byte  = acc[ACC_WIDTH-1 -: 8] | (8'hFF >> bit_count);
    pad_load  = (state == PAD) && can_load;
    byte_load = extract || pad_load;
    byte_in   = pad_load ? pad_byte : merged[ACC_WIDTH-1 -: 8];

    acc_next   = merged;
    count_next = merged_count;
    if (pad_load) begin
      acc_next   = '0;
      count_next = '0;
    end else if (extract) begin
      acc_next   = merged << 8;
      count_next = merged_count - CW'(8);
    end

    flush_done = (state == DONE) && !out_valid && !stuff_pending;
    busy       = (bit_count != '0) || out_valid || stuff_pending || (state != RUN);

    state_next = state;
    case (state)
      RUN:   if (flush) state_next = DRAIN;
      DRAIN: if (bit_count < CW'(8)) state_next = (bit_count != '0) ? PAD : DONE;
      PAD:   if (pad_load) state_next = DONE;
      DONE:  if (flush_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= RUN;
      acc       <= '0;
      bit_count <= '0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      bit_count <= count_next;
      in_ready  <= (state_next == RUN) && (count_next <= CW'(ACC_WIDTH - MAX_CODE_LEN));
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed and randomized checks of jpeg_bit_packer against a bit-queue reference model.
module tb_jpeg_bit_packer;

  logic        clock = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic [5:0]  in_length;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        flush_done;

  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  bit   mbits[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  jpeg_bit_packer #(.ACC_WIDTH(64), .MAX_CODE_LEN(32)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .in_valid   (in_valid),
    .in_length  (in_length),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .flush_done (flush_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte capture and hold-stability monitor.
  always @(negedge clock) begin
    if (!nreset) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_hold <= out_valid && !out_ready;
      prev_data <= out_data;
    end
  end

  always @(posedge clock) begin
    if (nreset && in_valid && in_ready) begin
      checks++;
      assert (in_length <= 6'd32) else begin
        errors++;
        $error("FAIL in_length observed %0d expected <=32", in_length);
      end
    end
  end

  function automatic void emit(input logic [7:0] b);
    exp_q.push_back(b);
    if (b == 8'hFF) exp_q.push_back(8'h00);
  endfunction

  function automatic void pop_byte();
    logic [7:0] b = '0;
    for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
    emit(b);
  endfunction

  function automatic void model_write(input int len, input logic [31:0] data);
    for (int i = len - 1; i >= 0; i--) mbits.push_back(data[i]);
    while (mbits.size() >= 8) pop_byte();
  endfunction

  function automatic void model_flush();
    if (mbits.size() > 0) begin
      while (mbits.size() < 8) mbits.push_back(1'b1);
      pop_byte();
    end
  endfunction

  task automatic write_word(input int len, input logic [31:0] data);
    in_valid  = 1'b1;
    in_length = 6'(len);
    in_data   = data;
    for (int n = 0; n < 300 && !in_ready; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    check("write_ready", in_ready, 1'b1);
    if (in_ready) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      model_write(len, data);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit seen = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    model_flush();
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clock);
      seen = flush_done;
    end
    check("flush_done_seen", seen, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    out_ready = 1'b1;
    for (int n = 0; n < 500 && busy; n++) @(negedge clock);
    check("idle", busy, 1'b0);
    @(posedge clock); #1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned words;
    logic [31:0] d;
    logic        rdy;

    nreset = 1'b0; in_valid = 1'b0; in_length = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    @(negedge clock) nreset = 1'b1;
    @(posedge clock); #1;
    check("release_in_ready", in_ready, 1'b1);

    // Two writes completing one byte; byte visible the cycle after acceptance.
    write_word(3, 32'h5);
    write_word(5, 32'h0);
    @(negedge clock);
    check("t1_latency_valid", out_valid, 1'b1);
    check("t1_latency_data", out_data, 8'hA0);
    @(posedge clock); #1;
    wait_idle();
    compare_stream("t1");

    write_word(8, 32'hFF);
    wait_idle();
    compare_stream("t2");

    write_word(32, 32'h12345678);
    write_word(3, 32'h5);
    do_flush();
    wait_idle();
    compare_stream("t3");

    write_word(3, 32'h6);
    do_flush();
    wait_idle();
    compare_stream("t4a");
    write_word(1, 32'h1);
    do_flush();
    wait_idle();
    compare_stream("t4b");

    // Empty flush: done exactly two cycles later.
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    check("empty_flush_c1", flush_done, 1'b0);
    @(negedge clock);
    check("empty_flush_c2", flush_done, 1'b1);
    @(posedge clock); #1;
    wait_idle();

    // Stall the consumer while offering full-width words every cycle.
    out_ready = 1'b0;
    words = 0;
    for (int c = 0; c < 20; c++) begin
      d = $urandom;
      rdy = in_ready;
      in_valid = 1'b1; in_length = 6'd32; in_data = d;
      @(posedge clock); #1;
      if (rdy) begin
        model_write(32, d);
        words++;
      end
    end
    in_valid = 1'b0;
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_words", words, 2);
    check("stall_out_valid", out_valid, 1'b1);
    do_flush();
    wait_idle();
    compare_stream("t5");

    // Randomized lengths/data with random back-pressure.
    for (int r = 0; r < 2; r++) begin
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
        int len;
        len = (i == 0) ? 32 : (i == 1) ? 0 : int'($urandom_range(0, 32));
        write_word(len, $urandom);
      end
      rand_ready = 1'b0;
      do_flush();
      wait_idle();
      compare_stream($sformatf("rand%0d", r));
    end

    // Reset mid-stream discards partial bits and the held byte.
    write_word(12, 32'hABC);
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    got.delete(); exp_q.delete(); mbits.delete();
    @(negedge clock) nreset = 1'b1;
    @(posedge clock); #1;
    write_word(8, 32'hA5);
    wait_idle();
    compare_stream("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
